multi_reaction_timer: RTL and testbench
=======================================

MULTI_REACTION_TIMER -- requirements
Module: multi_reaction_timer

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of player channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 12, reaction-time counter width in ticks.
REQ-003 SHALL have parameter TICK_DIV, default 1000, clk cycles per timing tick (>=2).
REQ-004 SHALL have parameter DLY_MIN, default 500, minimum random pre-delay in ticks.
REQ-005 SHALL have parameter DLY_RANGE_W, default 10, random pre-delay width; delay = DLY_MIN + lfsr[DLY_RANGE_W-1:0] ticks.
REQ-006 SHALL have parameter SPI_DIV, default 4, clk cycles per SPI half-period (>=1).
REQ-007 SHALL have port clk input 1, sole clock, all logic on rising edge.
REQ-008 SHALL have port rst_n input 1, reset, synchronous, active-low.
REQ-009 SHALL have port start input 1, round-start request, level sampled in IDLE.
REQ-010 SHALL have port btn input N_CH, raw asynchronous player buttons, active-high.
REQ-011 SHALL have port led output 1, "react now" indicator.
REQ-012 SHALL have port busy output 1, high in every state except IDLE.
REQ-013 SHALL have port done output 1, one-cycle pulse when the SPI frame completes.
REQ-014 SHALL have ports spi_sclk, spi_mosi, spi_cs_n, output 1 each, SPI master mode 0.

Function
REQ-015 SHALL implement states IDLE, WAIT, ARMED, SHIFT; transitions only as below.
REQ-016 SHALL pass each btn bit through a 2-flop synchroniser and rising-edge detector; press registered 3 cycles after pin rise.
REQ-017 SHALL run a free-running 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1) advancing every clk cycle.
REQ-018 IDLE: start=1 -> WAIT next cycle; load delay from current LFSR; clear all per-channel results, foul and hit flags; restart tick prescaler.
REQ-019 WAIT: press on channel i sets foul[i]; delay expiry -> ARMED; all channels foul -> SHIFT immediately.
REQ-020 ARMED: led=1; CNT_W-bit count starts at 0, increments once per tick; first press on non-foul channel i captures current count into time[i] and sets hit[i]; later presses ignored.
REQ-021 Same-cycle presses on several channels SHALL capture the identical count.
REQ-022 ARMED -> SHIFT when every non-foul channel has hit, or when count reaches 2^CNT_W-1 (saturate, no wrap); unhit non-foul channels get time all-ones and timeout bit set.
REQ-023 SHIFT: frame length N_CH*(CNT_W+2) bits, channel 0 first, per channel {foul, timeout, time[CNT_W-1:0]}, MSB first; foul channels send time=0.
REQ-024 SPI: sclk idle low, period 2*SPI_DIV cycles; cs_n falls with first bit on mosi; mosi changes only on sclk falling edge; cs_n rises SPI_DIV cycles after last falling edge.
REQ-025 On cs_n rise SHALL pulse done for one cycle and return to IDLE; led=0 outside ARMED.
REQ-026 start asserted while busy SHALL be ignored; start held high in IDLE after done SHALL begin a new round.

Reset
REQ-027 While rst_n=0 at a clk edge: state IDLE, led=0, busy=0, done=0, spi_sclk=0, spi_mosi=0, spi_cs_n=1, LFSR=16'hACE1, counters and flags 0.
REQ-028 Reset mid-round (including mid-frame) SHALL abort with outputs at reset values the following cycle; no partial done pulse.

Structure
REQ-029 Package reaction_timer_pkg SHALL hold the state enum, LFSR seed and tap constants, and a frame-width function of N_CH and CNT_W.
REQ-030 SPI serialisation SHALL live in sub-module spi_frame_tx (parallel load, start/done handshake, parametrised frame width and SPI_DIV).

Verification (params N_CH=2, CNT_W=8, TICK_DIV=4, DLY_MIN=3, DLY_RANGE_W=2, SPI_DIV=2)
REQ-031 Reset, start pulse, btn0 pressed 5 ticks after led rise, btn1 at 9 ticks -> frame bits 0,0,0x05,0,0,0x09, 20 sclk rising edges, done once.
REQ-032 btn1 pressed in WAIT, btn0 at 2 ticks -> ch1 {foul=1,timeout=0,time=0x00}, ch0 time 0x02; ARMED ends on ch0 hit.
REQ-033 Both buttons rise same cycle at 7 ticks -> both time 0x07.
REQ-034 No presses -> count saturates at 0xFF, both channels {0,1,0xFF}, led low on SHIFT entry.
REQ-035 Both buttons pressed in WAIT -> led never asserts, frame {1,0,0x00}x2.
REQ-036 rst_n low for 1 cycle at frame bit 10 -> next cycle cs_n=1, sclk=0, busy=0, no done; start during busy ignored.

Source files
------------

// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the multi-channel reaction timer.
// Holds the FSM state encodings, the LFSR seed/taps and the frame-size helper.
package reaction_timer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StArmed,
    StShift
  } rt_state_e;

  typedef enum logic [1:0] {
    SpiIdle,
    SpiLow,
    SpiHigh,
    SpiTail
  } spi_state_e;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic int unsigned frame_width(input int unsigned n_ch, input int unsigned cnt_w);
    return n_ch * (cnt_w + 2);
  endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// Mode-0 SPI master that shifts out one parallel-loaded frame, MSB first.
// done_o pulses for one cycle together with the rising edge of cs_no.
module spi_frame_tx
  import reaction_timer_pkg::*;
#(
  parameter int unsigned FrameW = 8,
  parameter int unsigned SpiDiv = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [FrameW-1:0] data_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic              cs_no,
  output logic              done_o
);

  localparam int unsigned DivW = (SpiDiv > 1) ? $clog2(SpiDiv) : 1;
  localparam int unsigned BitW = $clog2(FrameW + 1);

  spi_state_e        state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [BitW-1:0]   bits_q, bits_d;
  logic [FrameW-1:0] shreg_q, shreg_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              done_q, done_d;
  logic              half_end;

  assign half_end = (div_q == DivW'(SpiDiv - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= SpiIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SpiIdle: if (start_i) state_d = SpiLow;
      SpiLow:  if (half_end) state_d = SpiHigh;
      SpiHigh: if (half_end) state_d = (bits_q == '0) ? SpiTail : SpiLow;
      SpiTail: if (half_end) state_d = SpiIdle;
      default: state_d = SpiIdle;
    endcase
  end

  // mosi is the shift-register MSB, so it only moves on load and on sclk falls.
  always_comb begin
    div_d   = (state_q == SpiIdle || half_end) ? '0 : div_q + DivW'(1);
    bits_d  = bits_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    done_d  = 1'b0;
    unique case (state_q)
      SpiIdle: begin
        if (start_i) begin
          shreg_d = data_i;
          bits_d  = BitW'(FrameW - 1);
          cs_n_d  = 1'b0;
        end
      end
      SpiLow: begin
        if (half_end) sclk_d = 1'b1;
      end
      SpiHigh: begin
        if (half_end) begin
          sclk_d = 1'b0;
          if (bits_q != '0) begin
            shreg_d = {shreg_q[FrameW-2:0], 1'b0};
            bits_d  = bits_q - BitW'(1);
          end
        end
      end
      SpiTail: begin
        if (half_end) begin
          cs_n_d = 1'b1;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q   <= '0;
      bits_q  <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      bits_q  <= bits_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
    end
  end

  assign sclk_o = sclk_q;
  assign mosi_o = shreg_q[FrameW-1];
  assign cs_no  = cs_n_q;
  assign done_o = done_q;

endmodule

// File: rtl/multi_reaction_timer.sv
// Multi-player reaction timer: random pre-delay, per-channel reaction capture,
// foul detection, and a serial report of all channels over SPI.
module multi_reaction_timer
  import reaction_timer_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned TICK_DIV    = 1000,
  parameter int unsigned DLY_MIN     = 500,
  parameter int unsigned DLY_RANGE_W = 10,
  parameter int unsigned SPI_DIV     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [N_CH-1:0] btn,
  output logic            led,
  output logic            busy,
  output logic            done,
  output logic            spi_sclk,
  output logic            spi_mosi,
  output logic            spi_cs_n
);

  localparam int unsigned FrameW = frame_width(N_CH, CNT_W);
  localparam int unsigned ChW    = CNT_W + 2;
  localparam int unsigned TickW  = $clog2(TICK_DIV);
  localparam int unsigned DlyW   = $clog2(DLY_MIN + (1 << DLY_RANGE_W) + 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  rt_state_e state_q, state_d;

  logic [15:0]                 lfsr_q;
  logic [N_CH-1:0]             sync1_q, sync2_q, sync3_q;
  logic [N_CH-1:0]             press, cap;
  logic [TickW-1:0]            div_q;
  logic                        tick;
  logic [DlyW-1:0]             dly_q;
  logic [CNT_W-1:0]            count_q;
  logic [N_CH-1:0]             foul_q, hit_q, tout_q;
  logic [N_CH-1:0][CNT_W-1:0]  rt_time_q;
  logic                        sent_q;
  logic                        armed_exit;
  logic [FrameW-1:0]           frame;
  logic                        tx_start, tx_done;

  assign press      = sync2_q & ~sync3_q;
  assign cap        = press & ~foul_q & ~hit_q;
  assign tick       = (div_q == TickW'(TICK_DIV - 1));
  assign armed_exit = (state_q == StArmed) && (state_d == StShift);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StWait;
      StWait: begin
        if (&foul_q)            state_d = StShift;
        else if (dly_q == '0)   state_d = StArmed;
      end
      StArmed: if ((&(hit_q | foul_q)) || count_q == CntMax) state_d = StShift;
      StShift: if (tx_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    led      = (state_q == StArmed);
    busy     = (state_q != StIdle);
    tx_start = (state_q == StShift) && !sent_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q    <= LfsrSeed;
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
      div_q     <= '0;
      dly_q     <= '0;
      count_q   <= '0;
      foul_q    <= '0;
      hit_q     <= '0;
      tout_q    <= '0;
      rt_time_q <= '0;
      sent_q    <= 1'b0;
    end else begin
      lfsr_q  <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
      sync1_q <= btn;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      // Prescaler restarts on every state change so tick counts align to entry.
      if (state_q == StIdle || state_d != state_q || tick) begin
        div_q <= '0;
      end else begin
        div_q <= div_q + TickW'(1);
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            dly_q     <= DlyW'(DLY_MIN) + DlyW'(lfsr_q[DLY_RANGE_W-1:0]);
            count_q   <= '0;
            foul_q    <= '0;
            hit_q     <= '0;
            tout_q    <= '0;
            rt_time_q <= '0;
            sent_q    <= 1'b0;
          end
        end
        StWait: begin
          foul_q <= foul_q | press;
          if (tick && dly_q != '0) dly_q <= dly_q - DlyW'(1);
        end
        StArmed: begin
          if (tick && count_q != CntMax) count_q <= count_q + CNT_W'(1);
          hit_q <= hit_q | cap;
          for (int i = 0; i < N_CH; i++) begin
            if (cap[i]) begin
              rt_time_q[i] <= count_q;
            end else if (armed_exit && !hit_q[i] && !foul_q[i]) begin
              rt_time_q[i] <= CntMax;
            end
          end
          if (armed_exit) tout_q <= ~(hit_q | cap | foul_q);
        end
        StShift: begin
          if (tx_start) sent_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Channel 0 occupies the most significant field so it is shifted out first.
  always_comb begin
    frame = '0;
    for (int i = 0; i < N_CH; i++) begin
      frame[FrameW - 1 - i * ChW -: ChW] =
          {foul_q[i], tout_q[i], (foul_q[i] ? {CNT_W{1'b0}} : rt_time_q[i])};
    end
  end

  spi_frame_tx #(
    .FrameW(FrameW),
    .SpiDiv(SPI_DIV)
  ) u_spi_frame_tx (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .start_i(tx_start),
    .data_i (frame),
    .sclk_o (spi_sclk),
    .mosi_o (spi_mosi),
    .cs_no  (spi_cs_n),
    .done_o (tx_done)
  );

  assign done = tx_done;

endmodule

// File: tb/tb_multi_reaction_timer.sv
// Scoreboard bench for multi_reaction_timer: expected SPI frames are queued per
// round and compared against frames reassembled from the SPI pins.
`timescale 1ns/1ps
module tb_multi_reaction_timer;

  localparam int unsigned FrameW = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] btn = 2'b00;
  logic       led, busy, done, spi_sclk, spi_mosi, spi_cs_n;

  always #5 clk = ~clk;

  multi_reaction_timer #(
    .N_CH       (2),
    .CNT_W      (8),
    .TICK_DIV   (4),
    .DLY_MIN    (3),
    .DLY_RANGE_W(2),
    .SPI_DIV    (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .btn     (btn),
    .led     (led),
    .busy    (busy),
    .done    (done),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  logic [31:0]       exp_q[$];
  logic [31:0]       exp_frame;
  logic [FrameW-1:0] rx_sh = '0;
  int                rx_bits = 0;
  int                done_cnt = 0;
  int                led_rise_cnt = 0;
  bit                expect_abort = 1'b0;
  logic              prev_sclk = 1'b0, prev_cs = 1'b1, prev_led = 1'b0;

  // Pin monitor: rebuilds frames from the SPI lines and scores them.
  initial begin
    forever begin
      @(negedge clk);
      if (spi_cs_n === 1'b0 && prev_cs === 1'b1) begin
        rx_bits = 0;
        rx_sh   = '0;
        check_val("led_low_in_shift", {31'b0, led}, 32'd0);
      end
      if (spi_sclk === 1'b1 && prev_sclk === 1'b0 && spi_cs_n === 1'b0) begin
        rx_sh = {rx_sh[FrameW-2:0], spi_mosi};
        rx_bits++;
      end
      if (done === 1'b1) done_cnt++;
      if (led === 1'b1 && prev_led === 1'b0) led_rise_cnt++;
      if (spi_cs_n === 1'b1 && prev_cs === 1'b0) begin
        if (expect_abort) begin
          expect_abort = 1'b0;
          check_val("abort_no_done", {31'b0, done}, 32'd0);
        end else begin
          check_val("done_at_cs_rise", {31'b0, done}, 32'd1);
          check_val("sclk_rise_count", rx_bits, FrameW);
          check_val("frame_expected", {31'b0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            exp_frame = exp_q.pop_front();
            check_val("frame_bits", {12'b0, rx_sh}, exp_frame);
          end
        end
      end
      prev_sclk = spi_sclk;
      prev_cs   = spi_cs_n;
      prev_led  = led;
    end
  end

  function automatic logic [9:0] exp_field(input int mode, input int k);
    if (mode == 1)      return 10'h200;              // foul: {1,0,0x00}
    else if (mode == 2) return {2'b00, 8'(k)};       // hit at k ticks
    else                return 10'h1FF;              // timeout: {0,1,0xFF}
  endfunction

  task automatic wait_done(input int base, input string tag);
    int waited = 0;
    while (done_cnt == base && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    check_val(tag, done_cnt - base, 32'd1);
  endtask

  // mode: 0 = never press, 1 = press during WAIT, 2 = press k ticks after led rise.
  task automatic run_round(input int m0, input int k0, input int m1, input int k1,
                           input bit hold_start, input bit poke_start, input string tag);
    int base_done = done_cnt;
    int base_led  = led_rise_cnt;
    int mode[2];
    int k[2];
    int maxi = 0;
    int waited = 0;
    mode[0] = m0; mode[1] = m1;
    k[0] = k0;    k[1] = k1;
    exp_q.push_back({12'b0, exp_field(m0, k0), exp_field(m1, k1)});
    @(negedge clk) start = 1'b1;
    @(negedge clk) if (!hold_start) start = 1'b0;
    check_val({tag, "_busy"}, {31'b0, busy}, 32'd1);
    for (int c = 0; c < 2; c++) if (mode[c] == 1) btn[c] = 1'b1;
    if (!(m0 == 1 && m1 == 1)) begin
      while (led !== 1'b1 && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      check_val({tag, "_led_rise"}, {31'b0, led}, 32'd1);
      for (int c = 0; c < 2; c++) if (mode[c] == 2 && 4 * k[c] > maxi) maxi = 4 * k[c];
      for (int i = 0; i <= maxi; i++) begin
        for (int c = 0; c < 2; c++) if (mode[c] == 2 && i == 4 * k[c]) btn[c] = 1'b1;
        if (poke_start && i == 1) start = 1'b1;
        if (poke_start && i == 2) start = 1'b0;
        @(negedge clk);
      end
    end
    wait_done(base_done, {tag, "_done_once"});
    check_val({tag, "_led_rises"}, led_rise_cnt - base_led,
              (m0 == 1 && m1 == 1) ? 32'd0 : 32'd1);
    if (!hold_start) btn = 2'b00;
  endtask

  initial begin
    int base;
    int waited;
    repeat (3) @(negedge clk);
    check_val("rst_led", {31'b0, led}, 32'd0);
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_done", {31'b0, done}, 32'd0);
    check_val("rst_sclk", {31'b0, spi_sclk}, 32'd0);
    check_val("rst_mosi", {31'b0, spi_mosi}, 32'd0);
    check_val("rst_cs_n", {31'b0, spi_cs_n}, 32'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_round(2, 5, 2, 9, 1'b0, 1'b0, "basic");
    run_round(2, 2, 1, 0, 1'b0, 1'b1, "foul_ch1");
    repeat (2) @(negedge clk);
    check_val("start_ignored_when_busy", {31'b0, busy}, 32'd0);

    run_round(2, 7, 2, 7, 1'b1, 1'b0, "same_cycle");
    check_val("held_start_restarts", {31'b0, busy}, 32'd1);
    exp_q.push_back({12'b0, exp_field(0, 0), exp_field(0, 0)});
    start = 1'b0;
    btn   = 2'b00;
    base  = done_cnt;
    wait_done(base, "timeout_done_once");

    run_round(1, 0, 1, 0, 1'b0, 1'b0, "both_foul");

    // Abort mid-frame with a one-cycle reset.
    base = done_cnt;
    rx_bits = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    waited = 0;
    while (led !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    repeat (4) @(negedge clk);
    btn = 2'b11;
    waited = 0;
    while (!(spi_cs_n === 1'b0 && rx_bits >= 10) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check_val("abort_reached_bit10", {31'b0, rx_bits == 10}, 32'd1);
    expect_abort = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check_val("abort_cs_n", {31'b0, spi_cs_n}, 32'd1);
    check_val("abort_sclk", {31'b0, spi_sclk}, 32'd0);
    check_val("abort_busy", {31'b0, busy}, 32'd0);
    check_val("abort_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    btn   = 2'b00;
    repeat (40) @(negedge clk);
    check_val("abort_no_done_pulse", done_cnt - base, 32'd0);
    check_val("abort_idle", {31'b0, busy}, 32'd0);

    run_round(2, 3, 2, 1, 1'b0, 1'b0, "after_abort");
    check_val("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
